// File: rtl/wall_layout_gen_if.sv
// Wall layout bundle: level request / seed inputs and the committed wall origins.
// Latency: none, this is wiring only.
// Backpressure: none; the producer ignores new_level while busy, without queueing.
interface wall_layout_gen_if;
    logic       frame_clk;
    logic       new_level;
    logic       seed_load;
    logic [9:0] seed;
    logic [9:0] X1, Y1, X2, Y2, X3, Y3, X4, Y4;
    logic       busy;
    logic       layout_done;
    logic [3:0] fallback;

    // Layout generator side
    modport slave (
        input  frame_clk, new_level, seed_load, seed,
        output X1, Y1, X2, Y2, X3, Y3, X4, Y4, busy, layout_done, fallback
    );

    // Requester / renderer side
    modport master (
        output frame_clk, new_level, seed_load, seed,
        input  X1, Y1, X2, Y2, X3, Y3, X4, Y4, busy, layout_done, fallback
    );
endinterface

// File: rtl/wall_layout_gen.sv
// Random wall layout generator: LFSR candidates checked against bounds, spawns and earlier walls.
// Latency: new_level to layout_done is 1 + 4..4*MAX_TRIES + frame wait + 1 cycles.
// Backpressure: new_level is ignored while busy; outputs only move on the commit cycle.
module wall_layout_gen #(
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int HOR_W     = 64,
    parameter int HOR_H     = 32,
    parameter int VERT_W    = 32,
    parameter int VERT_H    = 64,
    parameter int GAP       = 8,
    parameter int SPAWN1_X  = 16,
    parameter int SPAWN1_Y  = 16,
    parameter int SPAWN2_X  = 592,
    parameter int SPAWN2_Y  = 432,
    parameter int SPAWN_SZ  = 32,
    parameter int MAX_TRIES = 64
) (
    input logic              Clk,
    input logic              Reset,
    wall_layout_gen_if.slave bus
);
    // Tries counter only ever holds 0..MAX_TRIES-1
    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    typedef logic [9:0] coord_t;
    localparam coord_t DEF_X [4] = '{10'd50,  10'd400, 10'd320, 10'd600};
    localparam coord_t DEF_Y [4] = '{10'd100, 10'd200, 10'd240, 10'd400};

    typedef enum logic [1:0] {IDLE, GEN, WAIT_FRAME, COMMIT} state_t;

    state_t        state_q;
    logic [15:0]   lfsr_q;
    logic [2:0]    fsync_q;      // [0],[1] synchroniser, [2] previous synced value
    logic [1:0]    w_q;          // wall being placed, 0-based
    logic [TW-1:0] tries_q;
    coord_t        sh_x_q [4];
    coord_t        sh_y_q [4];
    logic [3:0]    sh_fb_q;
    coord_t        x_q [4];
    coord_t        y_q [4];
    logic [3:0]    fb_q;
    logic          busy_q;
    logic          done_q;

    logic [15:0]   lfsr_d;
    logic [10:0]   cx, cy, cw, ch;
    logic          in_bounds, spawn_hit, wall_hit, accept, frame_tick;

    // Inclusive rectangle proximity; 11-bit so coordinate + extent + gap never wraps
    function automatic logic rect_near(input logic [10:0] ax, ay, aw, ah,
                                       input logic [10:0] bx, by, bw, bh, gap);
        return (ax <= bx + bw + gap) && (bx <= ax + aw + gap) &&
               (ay <= by + bh + gap) && (by <= ay + ah + gap);
    endfunction

    // Walls 1 and 3 (index 0, 2) are horizontal, walls 2 and 4 vertical
    function automatic logic [10:0] ext_w(input logic [1:0] idx);
        return idx[0] ? 11'(VERT_W) : 11'(HOR_W);
    endfunction

    function automatic logic [10:0] ext_h(input logic [1:0] idx);
        return idx[0] ? 11'(VERT_H) : 11'(HOR_H);
    endfunction

    assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cx         = {1'b0, lfsr_q[9:0]};
    assign cy         = {2'b00, lfsr_q[15:7]};
    assign cw         = ext_w(w_q);
    assign ch         = ext_h(w_q);
    assign in_bounds  = (cx + cw <= 11'(X_MAX)) && (cy + ch <= 11'(Y_MAX));
    assign spawn_hit  = rect_near(cx, cy, cw, ch, 11'(SPAWN1_X), 11'(SPAWN1_Y),
                                  11'(SPAWN_SZ), 11'(SPAWN_SZ), 11'd0) ||
                        rect_near(cx, cy, cw, ch, 11'(SPAWN2_X), 11'(SPAWN2_Y),
                                  11'(SPAWN_SZ), 11'(SPAWN_SZ), 11'd0);
    assign accept     = in_bounds && !spawn_hit && !wall_hit;
    assign frame_tick = fsync_q[1] & ~fsync_q[2];

    // Candidate must keep GAP clearance from every wall already placed in this layout
    always_comb begin
        wall_hit = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if ((2'(j) < w_q) &&
                rect_near(cx, cy, cw, ch, {1'b0, sh_x_q[j]}, {1'b0, sh_y_q[j]},
                          ext_w(2'(j)), ext_h(2'(j)), 11'(GAP)))
                wall_hit = 1'b1;
        end
    end

    // Control FSM, LFSR, frame-edge detector, shadow layout and committed outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            lfsr_q  <= 16'hACE1;
            fsync_q <= '0;
            w_q     <= '0;
            tries_q <= '0;
            sh_x_q  <= DEF_X;
            sh_y_q  <= DEF_Y;
            sh_fb_q <= '0;
            x_q     <= DEF_X;
            y_q     <= DEF_Y;
            fb_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsync_q <= {fsync_q[1:0], bus.frame_clk};
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Seed takes priority; a concurrent new_level starts GEN next cycle
                    if (bus.seed_load) begin
                        lfsr_q <= {6'h2B, bus.seed};
                    end else if (bus.new_level) begin
                        state_q <= GEN;
                        w_q     <= '0;
                        tries_q <= '0;
                        sh_fb_q <= '0;
                        busy_q  <= 1'b1;
                        for (int k = 0; k < 4; k++) begin
                            sh_x_q[k] <= '0;
                            sh_y_q[k] <= '0;
                        end
                    end
                end
                GEN: begin
                    lfsr_q <= lfsr_d;
                    if (accept || tries_q == TW'(MAX_TRIES - 1)) begin
                        if (accept) begin
                            sh_x_q[w_q] <= cx[9:0];
                            sh_y_q[w_q] <= cy[9:0];
                        end else begin
                            sh_x_q[w_q]  <= DEF_X[w_q];
                            sh_y_q[w_q]  <= DEF_Y[w_q];
                            sh_fb_q[w_q] <= 1'b1;
                        end
                        tries_q <= '0;
                        w_q     <= w_q + 2'd1;
                        if (w_q == 2'd3)
                            state_q <= WAIT_FRAME;
                    end else begin
                        tries_q <= tries_q + TW'(1);
                    end
                end
                WAIT_FRAME: begin
                    // Whole layout moves at once so the renderer never sees a mix
                    if (frame_tick) begin
                        state_q <= COMMIT;
                        x_q     <= sh_x_q;
                        y_q     <= sh_y_q;
                        fb_q    <= sh_fb_q;
                        done_q  <= 1'b1;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.X1          = x_q[0];
    assign bus.Y1          = y_q[0];
    assign bus.X2          = x_q[1];
    assign bus.Y2          = y_q[1];
    assign bus.X3          = x_q[2];
    assign bus.Y3          = y_q[2];
    assign bus.X4          = x_q[3];
    assign bus.Y4          = y_q[3];
    assign bus.busy        = busy_q;
    assign bus.layout_done = done_q;
    assign bus.fallback    = fb_q;
endmodule

// File: tb/tb_wall_layout_gen.sv
// Directed bench for wall_layout_gen: reset layout, seeded generation, determinism, busy behaviour, fallback, reset in GEN.
// Latency: expectations come from a behavioural LFSR/placement model and hand constants.
// Backpressure: new_level pulses during busy are expected to be dropped.
module tb_wall_layout_gen;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    wall_layout_gen_if bus1 ();
    wall_layout_gen_if bus2 ();

    wall_layout_gen dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));
    wall_layout_gen #(.MAX_TRIES(1)) dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;

    localparam int DX [4] = '{50, 400, 320, 600};
    localparam int DY [4] = '{100, 200, 240, 400};

    int         exp_x [4];
    int         exp_y [4];
    logic [3:0] exp_fb;
    int         got_x [4];
    int         got_y [4];
    int         t2_x  [4];
    int         t2_y  [4];
    logic [3:0] t2_fb;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic snap1();
        got_x[0] = int'(bus1.X1); got_y[0] = int'(bus1.Y1);
        got_x[1] = int'(bus1.X2); got_y[1] = int'(bus1.Y2);
        got_x[2] = int'(bus1.X3); got_y[2] = int'(bus1.Y3);
        got_x[3] = int'(bus1.X4); got_y[3] = int'(bus1.Y4);
    endtask

    // Behavioural placement model: walk the LFSR sequence and place four walls
    task automatic model_run(input logic [15:0] l0, input int mt);
        logic [15:0] l;
        int cx, cy, ww, hh, tries, wj, hj;
        bit placed, ok;
        l = l0;
        exp_fb = 4'b0000;
        for (int w = 0; w < 4; w++) begin
            ww = (w % 2 == 0) ? 64 : 32;
            hh = (w % 2 == 0) ? 32 : 64;
            tries = 0;
            placed = 1'b0;
            while (!placed) begin
                cx = int'(l & 16'h03FF);
                cy = int'(l >> 7);
                l = {l[14:0], ^(l & 16'hB400)};
                ok = (cx + ww <= 639) && (cy + hh <= 479);
                if (!(cx + ww < 16 || cx > 48 || cy + hh < 16 || cy > 48)) ok = 1'b0;
                if (!(cx + ww < 592 || cx > 624 || cy + hh < 432 || cy > 464)) ok = 1'b0;
                for (int j = 0; j < w; j++) begin
                    wj = (j % 2 == 0) ? 64 : 32;
                    hj = (j % 2 == 0) ? 32 : 64;
                    if (!(cx > exp_x[j] + wj + 8 || exp_x[j] > cx + ww + 8 ||
                          cy > exp_y[j] + hj + 8 || exp_y[j] > cy + hh + 8)) ok = 1'b0;
                end
                if (ok) begin
                    exp_x[w] = cx;
                    exp_y[w] = cy;
                    placed = 1'b1;
                end else begin
                    tries++;
                    if (tries == mt) begin
                        exp_x[w] = DX[w];
                        exp_y[w] = DY[w];
                        exp_fb[w] = 1'b1;
                        placed = 1'b1;
                    end
                end
            end
        end
    endtask

    // One full level request on bus1 with a frame edge 300 cycles after new_level
    task automatic run_level1(input bit do_seed, input logic [9:0] s,
                              output bit stable, output int early, output bit busy_w,
                              output int pulses, output int done_at);
        int px [4];
        int py [4];
        snap1();
        px = got_x;
        py = got_y;
        if (do_seed) begin
            bus1.seed_load = 1'b1;
            bus1.seed = s;
            tick();
            bus1.seed_load = 1'b0;
        end
        bus1.new_level = 1'b1;
        tick();
        bus1.new_level = 1'b0;
        stable = 1'b1;
        early = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            snap1();
            for (int k = 0; k < 4; k++)
                if (got_x[k] != px[k] || got_y[k] != py[k]) stable = 1'b0;
            if (bus1.layout_done === 1'b1) early++;
        end
        busy_w = bus1.busy;
        bus1.frame_clk = 1'b1;
        pulses = 0;
        done_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus1.layout_done === 1'b1) begin
                pulses++;
                if (done_at == 0) done_at = i;
            end
        end
        bus1.frame_clk = 1'b0;
        tick(); tick(); tick();
        snap1();
    endtask

    task automatic test_reset();
        bit ok;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        snap1();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_x[k] !== DX[k] || got_y[k] !== DY[k]) begin
                n_bad++;
                $display("FAIL reset_pos wall%0d: got (%0d,%0d) want (%0d,%0d)", k + 1, got_x[k], got_y[k], DX[k], DY[k]);
            end
        end
        n_cmp++;
        if (bus1.busy !== 1'b0 || bus1.layout_done !== 1'b0 || bus1.fallback !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_flags: got busy=%b done=%b fb=%h want 0 0 0", bus1.busy, bus1.layout_done, bus1.fallback);
        end
        ok = (bus2.X1 == 10'd50) && (bus2.Y4 == 10'd400) && (bus2.busy == 1'b0) && (bus2.fallback == 4'h0);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL reset_dut2: got X1=%0d Y4=%0d busy=%b fb=%h want 50 400 0 0", bus2.X1, bus2.Y4, bus2.busy, bus2.fallback);
        end
    endtask

    task automatic test_seeded_layout();
        bit stable, busy_w, props_ok;
        int early, pulses, done_at, ww, hh, wj, hj;
        logic [3:0] fbv;
        run_level1(1'b1, 10'h155, stable, early, busy_w, pulses, done_at);
        model_run(16'hAD55, 64);
        n_cmp++;
        if (!stable || early != 0) begin
            n_bad++;
            $display("FAIL seeded_hold: got stable=%0d early_pulses=%0d want 1 0", stable, early);
        end
        n_cmp++;
        if (busy_w !== 1'b1) begin
            n_bad++;
            $display("FAIL seeded_busy_wait: got %b want 1", busy_w);
        end
        n_cmp++;
        if (pulses != 1 || done_at != 3) begin
            n_bad++;
            $display("FAIL seeded_done: got pulses=%0d at=%0d want 1 at 3", pulses, done_at);
        end
        n_cmp++;
        if (bus1.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL seeded_busy_end: got %b want 0", bus1.busy);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_x[k] !== exp_x[k] || got_y[k] !== exp_y[k]) begin
                n_bad++;
                $display("FAIL seeded_pos wall%0d: got (%0d,%0d) want (%0d,%0d)", k + 1, got_x[k], got_y[k], exp_x[k], exp_y[k]);
            end
        end
        n_cmp++;
        if (bus1.fallback !== exp_fb) begin
            n_bad++;
            $display("FAIL seeded_fallback: got %b want %b", bus1.fallback, exp_fb);
        end
        fbv = bus1.fallback;
        props_ok = 1'b1;
        for (int w = 0; w < 4; w++) begin
            ww = (w % 2 == 0) ? 64 : 32;
            hh = (w % 2 == 0) ? 32 : 64;
            if (!fbv[w]) begin
                if (got_x[w] + ww > 639 || got_y[w] + hh > 479) props_ok = 1'b0;
                if (got_x[w] <= 48 && got_x[w] + ww >= 16 && got_y[w] <= 48 && got_y[w] + hh >= 16) props_ok = 1'b0;
                if (got_x[w] <= 624 && got_x[w] + ww >= 592 && got_y[w] <= 464 && got_y[w] + hh >= 432) props_ok = 1'b0;
                for (int j = 0; j < w; j++) begin
                    wj = (j % 2 == 0) ? 64 : 32;
                    hj = (j % 2 == 0) ? 32 : 64;
                    if (!fbv[j] && got_x[w] <= got_x[j] + wj + 8 && got_x[j] <= got_x[w] + ww + 8 &&
                        got_y[w] <= got_y[j] + hj + 8 && got_y[j] <= got_y[w] + hh + 8) props_ok = 1'b0;
                end
            end
        end
        n_cmp++;
        if (!props_ok) begin
            n_bad++;
            $display("FAIL seeded_geometry: got bound/spawn/clearance violation want none");
        end
        t2_x = got_x;
        t2_y = got_y;
        t2_fb = bus1.fallback;
    endtask

    task automatic test_determinism();
        bit stable, busy_w;
        int early, pulses, done_at;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        snap1();
        n_cmp++;
        if (got_x[0] !== 50 || got_y[3] !== 400 || bus1.fallback !== 4'h0) begin
            n_bad++;
            $display("FAIL determ_reset: got X1=%0d Y4=%0d fb=%h want 50 400 0", got_x[0], got_y[3], bus1.fallback);
        end
        run_level1(1'b1, 10'h155, stable, early, busy_w, pulses, done_at);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_x[k] !== t2_x[k] || got_y[k] !== t2_y[k]) begin
                n_bad++;
                $display("FAIL determ_pos wall%0d: got (%0d,%0d) want (%0d,%0d)", k + 1, got_x[k], got_y[k], t2_x[k], t2_y[k]);
            end
        end
        n_cmp++;
        if (bus1.fallback !== t2_fb || pulses != 1 || !stable) begin
            n_bad++;
            $display("FAIL determ_misc: got fb=%b pulses=%0d stable=%0d want fb=%b 1 1", bus1.fallback, pulses, stable, t2_fb);
        end
    endtask

    task automatic test_back_to_back();
        bit busy_ok;
        int early, pulses, extra, done_at;
        bus1.seed_load = 1'b1;
        bus1.seed = 10'h155;
        tick();
        bus1.seed_load = 1'b0;
        bus1.new_level = 1'b1;
        tick();
        busy_ok = 1'b1;
        early = 0;
        for (int i = 0; i < 300; i++) begin
            bus1.new_level = (i == 2 || i == 280) ? 1'b0 : 1'b1;
            tick();
            if (bus1.busy !== 1'b1) busy_ok = 1'b0;
            if (bus1.layout_done === 1'b1) early++;
        end
        bus1.frame_clk = 1'b1;
        pulses = 0;
        done_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus1.layout_done === 1'b1) begin
                pulses++;
                if (done_at == 0) done_at = i;
                bus1.new_level = 1'b0;
            end
        end
        bus1.new_level = 1'b0;
        bus1.frame_clk = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus1.layout_done === 1'b1) extra++;
        end
        snap1();
        model_run(16'hAD55, 64);
        n_cmp++;
        if (!busy_ok || early != 0) begin
            n_bad++;
            $display("FAIL b2b_busy: got busy_ok=%0d early=%0d want 1 0", busy_ok, early);
        end
        n_cmp++;
        if (pulses != 1 || extra != 0 || done_at != 3) begin
            n_bad++;
            $display("FAIL b2b_done: got pulses=%0d extra=%0d at=%0d want 1 0 3", pulses, extra, done_at);
        end
        n_cmp++;
        if (bus1.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: got busy=%b want 0", bus1.busy);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_x[k] !== exp_x[k] || got_y[k] !== exp_y[k]) begin
                n_bad++;
                $display("FAIL b2b_pos wall%0d: got (%0d,%0d) want (%0d,%0d)", k + 1, got_x[k], got_y[k], exp_x[k], exp_y[k]);
            end
        end
    endtask

    task automatic test_fallback();
        int early, pulses;
        int gx [4];
        int gy [4];
        bus2.seed_load = 1'b1;
        bus2.seed = 10'h3FF;
        tick();
        bus2.seed_load = 1'b0;
        bus2.new_level = 1'b1;
        tick();
        bus2.new_level = 1'b0;
        early = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus2.layout_done === 1'b1) early++;
        end
        bus2.frame_clk = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus2.layout_done === 1'b1) pulses++;
        end
        bus2.frame_clk = 1'b0;
        n_cmp++;
        if (bus2.X1 !== 10'd50 || bus2.Y1 !== 10'd100) begin
            n_bad++;
            $display("FAIL fallback_w1: got (%0d,%0d) want (50,100)", bus2.X1, bus2.Y1);
        end
        n_cmp++;
        if (bus2.fallback[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL fallback_bit0: got %b want 1", bus2.fallback[0]);
        end
        model_run(16'hAFFF, 1);
        gx = '{int'(bus2.X1), int'(bus2.X2), int'(bus2.X3), int'(bus2.X4)};
        gy = '{int'(bus2.Y1), int'(bus2.Y2), int'(bus2.Y3), int'(bus2.Y4)};
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if (gx[k] !== exp_x[k] || gy[k] !== exp_y[k]) begin
                n_bad++;
                $display("FAIL fallback_pos wall%0d: got (%0d,%0d) want (%0d,%0d)", k + 1, gx[k], gy[k], exp_x[k], exp_y[k]);
            end
        end
        n_cmp++;
        if (bus2.fallback !== exp_fb || pulses != 1 || early != 0) begin
            n_bad++;
            $display("FAIL fallback_misc: got fb=%b pulses=%0d early=%0d want fb=%b 1 0", bus2.fallback, pulses, early, exp_fb);
        end
    endtask

    task automatic test_reset_in_gen();
        bit busy_gen, stable, busy_w;
        int stray, early, pulses, done_at;
        bus1.seed_load = 1'b1;
        bus1.seed = 10'h155;
        tick();
        bus1.seed_load = 1'b0;
        bus1.new_level = 1'b1;
        tick();
        bus1.new_level = 1'b0;
        tick();
        busy_gen = bus1.busy;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        snap1();
        n_cmp++;
        if (busy_gen !== 1'b1) begin
            n_bad++;
            $display("FAIL rstgen_busy_before: got %b want 1", busy_gen);
        end
        n_cmp++;
        if (bus1.busy !== 1'b0 || bus1.layout_done !== 1'b0 || bus1.fallback !== 4'h0) begin
            n_bad++;
            $display("FAIL rstgen_flags: got busy=%b done=%b fb=%h want 0 0 0", bus1.busy, bus1.layout_done, bus1.fallback);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_x[k] !== DX[k] || got_y[k] !== DY[k]) begin
                n_bad++;
                $display("FAIL rstgen_pos wall%0d: got (%0d,%0d) want (%0d,%0d)", k + 1, got_x[k], got_y[k], DX[k], DY[k]);
            end
        end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus1.layout_done === 1'b1 || bus1.busy === 1'b1) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL rstgen_quiet: got %0d active cycles want 0", stray);
        end
        // Unseeded run must follow the reset LFSR value
        run_level1(1'b0, 10'h000, stable, early, busy_w, pulses, done_at);
        model_run(16'hACE1, 64);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_x[k] !== exp_x[k] || got_y[k] !== exp_y[k]) begin
                n_bad++;
                $display("FAIL rstgen_lfsr wall%0d: got (%0d,%0d) want (%0d,%0d)", k + 1, got_x[k], got_y[k], exp_x[k], exp_y[k]);
            end
        end
        n_cmp++;
        if (bus1.fallback !== exp_fb || pulses != 1) begin
            n_bad++;
            $display("FAIL rstgen_lfsr_misc: got fb=%b pulses=%0d want fb=%b 1", bus1.fallback, pulses, exp_fb);
        end
    endtask

    initial begin
        Reset = 1'b1;
        bus1.frame_clk = 1'b0; bus1.new_level = 1'b0; bus1.seed_load = 1'b0; bus1.seed = '0;
        bus2.frame_clk = 1'b0; bus2.new_level = 1'b0; bus2.seed_load = 1'b0; bus2.seed = '0;
        test_reset();
        test_seeded_layout();
        test_determinism();
        test_back_to_back();
        test_fallback();
        test_reset_in_gen();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
